// File: rtl/press_arbiter_if.sv
// Button/command bus between raw push-button inputs, the arbiter and the shared resource.
interface press_arbiter_if #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = $clog2(N)
);
    logic [N-1:0]   bi;
    logic           done;
    logic           go;
    logic [IDW-1:0] go_id;
    logic [N-1:0]   pending;
    logic           drop;
    logic           timeout;

    modport master (
        output bi, done,
        input  go, go_id, pending, drop, timeout
    );

    modport slave (
        input  bi, done,
        output go, go_id, pending, drop, timeout
    );
endinterface

// File: rtl/press_arbiter.sv
// Edge-detects N button channels, latches presses as pending and grants one at a time
// round-robin to a single resource using a go/done handshake with a timeout guard.
module press_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input logic              clk,
    input logic              rst,
    press_arbiter_if.slave   bus
);
    localparam int unsigned IDW = $clog2(N);
    localparam int unsigned CW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   prev_q;
    logic [N-1:0]   pending_q, pending_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] go_id_q, go_id_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           drop_q, drop_d;
    logic           timeout_q, timeout_d;

    logic [N-1:0]   edge_c;
    logic [N-1:0]   clr_c;
    logic           pick_found_c;
    logic [IDW-1:0] pick_idx_c;

    assign edge_c = bus.bi & ~prev_q;

    // Channel cleared on the edge leaving ISSUE; a same-edge press re-sets it.
    always_comb begin
        clr_c = '0;
        if (state_q == ISSUE) begin
            clr_c[go_id_q] = 1'b1;
        end
    end

    assign pending_d = (pending_q & ~clr_c) | edge_c;
    assign drop_d    = |(edge_c & pending_q & ~clr_c);

    // First pending channel searching ptr, ptr+1, ... wrapping at N.
    always_comb begin
        pick_found_c = 1'b0;
        pick_idx_c   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            logic [IDW-1:0] cand;
            cand = IDW'((32'(ptr_q) + k) % N);
            if (!pick_found_c && pending_q[cand]) begin
                pick_found_c = 1'b1;
                pick_idx_c   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        go_id_d   = go_id_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_found_c) begin
                    go_id_d = pick_idx_c;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                ptr_d   = (go_id_q == IDW'(N - 1)) ? '0 : go_id_q + IDW'(1);
                cnt_d   = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.done) begin
                    state_d = IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            pending_q <= '0;
            ptr_q     <= '0;
            go_id_q   <= '0;
            cnt_q     <= '0;
            drop_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= bus.bi;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            go_id_q   <= go_id_d;
            cnt_q     <= cnt_d;
            drop_q    <= drop_d;
            timeout_q <= timeout_d;
        end
    end

    // go is a pure decode of the state register, so it falls with an async reset.
    assign bus.go      = (state_q == ISSUE);
    assign bus.go_id   = go_id_q;
    assign bus.pending = pending_q;
    assign bus.drop    = drop_q;
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_press_arbiter.sv
// Bench for press_arbiter: directed scenarios plus random presses against a
// transaction-level model of pending requests and round-robin grants.
module tb_press_arbiter;
    localparam int N       = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst;

    press_arbiter_if #(.N(N), .IDW(IDW)) bus ();

    press_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: phase 0 = nothing granted, 1 = grant strobe cycle, 2 = waiting on resource.
    int          m_phase;
    int          m_wait;
    int          m_id;
    int          m_last;
    bit [N-1:0]  m_pend;
    bit [N-1:0]  m_prev;
    bit          m_drop;
    bit          m_to;
    int          done_delay;
    int          n_go;
    int          n_to;
    int          n_drop;

    function automatic void model_reset();
        m_phase = 0;
        m_wait  = 0;
        m_id    = 0;
        m_last  = N - 1;
        m_pend  = '0;
        m_prev  = '0;
        m_drop  = 1'b0;
        m_to    = 1'b0;
    endfunction

    function automatic void model_step(input logic [N-1:0] b, input logic d);
        bit [N-1:0] old_pend;
        int         served;
        bit         nd;
        bit         nt;
        bit         found;
        old_pend = m_pend;
        served   = (m_phase == 1) ? m_id : -1;
        nd       = 1'b0;
        nt       = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (b[i] && !m_prev[i] && old_pend[i] && i != served) nd = 1'b1;
        end
        case (m_phase)
            0: begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (!found && old_pend[c]) begin
                        found   = 1'b1;
                        m_id    = c;
                        m_phase = 1;
                    end
                end
            end
            1: begin
                m_phase = 2;
                m_wait  = 0;
                m_last  = m_id;
            end
            default: begin
                m_wait++;
                if (d) begin
                    m_phase = 0;
                end else if (m_wait == TIMEOUT) begin
                    m_phase = 0;
                    nt      = 1'b1;
                end
            end
        endcase
        for (int i = 0; i < N; i++) begin
            if (i == served) m_pend[i] = 1'b0;
            if (b[i] && !m_prev[i]) m_pend[i] = 1'b1;
        end
        m_prev = b;
        m_drop = nd;
        m_to   = nt;
    endfunction

    task automatic compare_all();
        check("go",      32'(bus.go),      32'(m_phase == 1));
        check("go_id",   32'(bus.go_id),   32'(m_id));
        check("pending", 32'(bus.pending), 32'(m_pend));
        check("drop",    32'(bus.drop),    32'(m_drop));
        check("timeout", 32'(bus.timeout), 32'(m_to));
        if (bus.go === 1'b1)      n_go++;
        if (bus.timeout === 1'b1) n_to++;
        if (bus.drop === 1'b1)    n_drop++;
    endtask

    // One clock: drive inputs away from the edge, advance the model, sample 1 time unit later.
    task automatic cycle(input logic [N-1:0] bi_v);
        logic d;
        if (done_delay < 0) d = ($urandom_range(0, 3) == 0);
        else                d = (m_phase == 2) && (m_wait >= done_delay);
        bus.bi   = bi_v;
        bus.done = d;
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(bi_v, d);
        #1;
        compare_all();
    endtask

    task automatic run(input logic [N-1:0] bi_v, input int n);
        for (int i = 0; i < n; i++) cycle(bi_v);
    endtask

    initial begin
        logic [N-1:0] cur;
        rst        = 1'b1;
        bus.bi     = '0;
        bus.done   = 1'b0;
        done_delay = 0;
        n_go       = 0;
        n_to       = 0;
        n_drop     = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;

        // Single held press on channel 2: exactly one grant.
        n_go = 0;
        run(4'b0100, 5);
        run(4'b0000, 8);
        check("single_press_go_count", 32'(n_go), 32'd1);

        // Simultaneous presses served 0,1,3.
        n_go = 0;
        run(4'b1011, 1);
        run(4'b0000, 12);
        check("multi_press_go_count", 32'(n_go), 32'd3);

        // Fairness: channel 1 in flight, then 0 and 2 pressed.
        done_delay = 3;
        run(4'b0010, 1);
        run(4'b0000, 2);
        run(4'b0101, 1);
        run(4'b0000, 20);

        // Drop: repeat press of a pending channel while another grant waits on done.
        done_delay = 1000;
        run(4'b0001, 1);
        run(4'b0000, 3);
        n_drop = 0;
        run(4'b0010, 1);
        run(4'b0000, 1);
        run(4'b0010, 1);
        run(4'b0000, 1);
        check("drop_count", 32'(n_drop), 32'd1);
        done_delay = 0;
        run(4'b0000, 15);

        // Timeout on channel 3, then a normal grant for channel 0.
        done_delay = 1000;
        n_to = 0;
        run(4'b1000, 1);
        run(4'b0000, 14);
        check("timeout_count", 32'(n_to), 32'd1);
        done_delay = 0;
        run(4'b0001, 1);
        run(4'b0000, 6);

        // done coinciding with the last wait cycle suppresses the timeout pulse.
        done_delay = TIMEOUT - 1;
        n_to = 0;
        run(4'b0100, 1);
        run(4'b0000, 14);
        check("done_beats_timeout", 32'(n_to), 32'd0);

        // Async reset in the middle of a wait with channels 1 and 2 pending.
        done_delay = 1000;
        run(4'b0001, 1);
        run(4'b0000, 2);
        run(4'b0110, 2);
        check("pre_reset_pending", 32'(bus.pending), 32'd6);
        #2;
        rst = 1'b1;
        #1;
        check("async_go",      32'(bus.go),      32'd0);
        check("async_pending", 32'(bus.pending), 32'd0);
        check("async_go_id",   32'(bus.go_id),   32'd0);
        model_reset();
        run(4'b0000, 2);
        rst = 1'b0;
        done_delay = 0;
        run(4'b0000, 1);
        run(4'b0100, 1);
        run(4'b0000, 6);

        // Random presses and random done timing.
        done_delay = -1;
        cur = '0;
        for (int i = 0; i < 600; i++) begin
            logic [N-1:0] flip;
            for (int j = 0; j < N; j++) flip[j] = ($urandom_range(0, 4) == 0);
            cur = cur ^ flip;
            cycle(cur);
        end
        run(4'b0000, 3 * TIMEOUT * N);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
